sdram_write_feeder: RTL

- Producer for the SDRAM controller's write port, clocked on the controller clock.
- Accepts a valid/ready pixel word stream and buffers it in an internal show-ahead FIFO.
- Advertises a burst to the controller via WR_LENGTH only when a full burst is buffered, then supplies one word per WR_REQ cycle.
- Also issues WR_LOAD at frame start and reports frame completion.

---
 rtl/sdram_write_feeder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_write_feeder.sv
// Write-port producer for the SDRAM controller: buffers a pixel stream in a show-ahead FIFO
// and offers fixed-length bursts once a whole burst is buffered.
module sdram_write_feeder #(
   parameter int unsigned DSIZE       = 32,
   parameter int unsigned ASIZE       = 22,
   parameter int unsigned BURST_LEN   = 256,
   parameter int unsigned FIFO_DEPTH  = 512,
   parameter int unsigned FRAME_BASE  = 0,
   parameter int unsigned FRAME_WORDS = 384000
) (
   input  logic             REF_CLK,
   input  logic             RESET_N,
   input  logic [DSIZE-1:0] PIX_DATA,
   input  logic             PIX_VALID,
   output logic             PIX_READY,
   input  logic             FRAME_START,
   output logic [DSIZE-1:0] WR_DATA,
   input  logic             WR_REQ,
   input  logic             WR_DONE,
   output logic [23:0]      WR_LENGTH,
   output logic             WR_LOAD,
   output logic [ASIZE-1:0] WR_MIN_ADDR,
   output logic [ASIZE-1:0] WR_MAX_ADDR,
   output logic             FRAME_DONE,
   output logic             UNDERFLOW
);

   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned NBURST = FRAME_WORDS / BURST_LEN;
   localparam int unsigned BCW    = $clog2(NBURST + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FILL,
      S_ARMED,
      S_BURST
   } state_t;

   state_t           state_q, state_d;
   logic [DSIZE-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DSIZE-1:0] last_q;
   logic             pending_q, pending_d;
   logic [BCW-1:0]   bcnt_q, bcnt_d;
   logic             frame_done_q, frame_done_d;
   logic             underflow_q, underflow_d;
   logic [23:0]      wr_len_q, wr_len_d;

   logic             pix_ready;
   logic             push, pop;

   assign push = PIX_VALID & pix_ready;
   assign pop  = WR_REQ & (count_q != '0);

   // FIFO bookkeeping; the LOAD cycle discards everything buffered.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (state_q == S_LOAD) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge REF_CLK) begin
      if (push) mem_q[wr_ptr_q] <= PIX_DATA;
   end

   always_ff @(posedge REF_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (pop) last_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge REF_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         pending_q    <= 1'b0;
         bcnt_q       <= '0;
         frame_done_q <= 1'b0;
         underflow_q  <= 1'b0;
         wr_len_q     <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         bcnt_q       <= bcnt_d;
         frame_done_q <= frame_done_d;
         underflow_q  <= underflow_d;
         wr_len_q     <= wr_len_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      bcnt_d       = bcnt_q;
      frame_done_d = 1'b0;
      underflow_d  = underflow_q | (WR_REQ & (count_q == '0));
      case (state_q)
         S_IDLE: begin
            if (FRAME_START) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d     = S_FILL;
            pending_d   = 1'b0;
            bcnt_d      = '0;
            underflow_d = 1'b0;
         end
         S_FILL: begin
            if (FRAME_START || pending_q) begin
               state_d   = S_LOAD;
               pending_d = 1'b0;
            end else if (count_d >= CW'(BURST_LEN)) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (FRAME_START) pending_d = 1'b1;
            if (WR_REQ) state_d = S_BURST;
         end
         S_BURST: begin
            if (FRAME_START) pending_d = 1'b1;
            if (WR_DONE) begin
               // A frame restart is only honoured here, once the committed burst has retired.
               if (bcnt_q + BCW'(1) == BCW'(NBURST)) begin
                  bcnt_d       = '0;
                  frame_done_d = 1'b1;
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
               if (pending_q || FRAME_START) begin
                  state_d   = S_LOAD;
                  pending_d = 1'b0;
               end else if (count_d >= CW'(BURST_LEN)) begin
                  state_d = S_ARMED;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      wr_len_d = ((state_d == S_ARMED) || (state_d == S_BURST)) ? 24'(BURST_LEN) : '0;
   end

   always_comb begin
      pix_ready   = (count_q < CW'(FIFO_DEPTH)) && (state_q != S_LOAD) && (state_q != S_IDLE);
      PIX_READY   = pix_ready;
      WR_LOAD     = (state_q == S_LOAD);
      WR_DATA     = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
      WR_LENGTH   = wr_len_q;
      FRAME_DONE  = frame_done_q;
      UNDERFLOW   = underflow_q;
      WR_MIN_ADDR = ASIZE'(FRAME_BASE);
      WR_MAX_ADDR = ASIZE'(FRAME_BASE + FRAME_WORDS);
   end

endmodule
